// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - shares one single-beat memory bus between the instruction fetch and data ports
//
// Purpose:
//   Latches single-cycle fetch/load/store strobes into per-side pending
//   registers. Grants the shared bus to one side at a time and breaks ties
//   round-robin. Produces the BUSY/DONE pairs that the hazard unit uses to
//   stall and release the pipeline.
//
// Optional build macro:
//   CORE_MEM_ARB_TIMEOUT_EN - abandons a grant after TIMEOUT_CYCLES cycles
//                             without BUS_READY and reports it with DONE+ERR.
//
// Ports:
//   CLK, NRST            clock; synchronous active-low reset
//   IMEM_REQ/ADDR        fetch strobe and address
//   IMEM_RDATA/BUSY/DONE/ERR  fetch result, stall, completion pulse, error
//   DMEM_REQ_LOAD/STORE  data strobes (both set together = store)
//   DMEM_ADDR/WDATA/STRB data address, store data, byte enables
//   DMEM_RDATA/BUSY/DONE/ERR  load result, stall, completion pulse, error
//   BUS_VALID/WRITE/ADDR/WDATA/STRB  shared bus request
//   BUS_READY/RDATA      bus completion and read data

module core_mem_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          CLK,
    input  logic          NRST,
    input  logic          IMEM_REQ,
    input  logic [AW-1:0] IMEM_ADDR,
    output logic [DW-1:0] IMEM_RDATA,
    output logic          IMEM_BUSY,
    output logic          IMEM_DONE,
    output logic          IMEM_ERR,
    input  logic          DMEM_REQ_LOAD,
    input  logic          DMEM_REQ_STORE,
    input  logic [AW-1:0] DMEM_ADDR,
    input  logic [DW-1:0] DMEM_WDATA,
    input  logic [3:0]    DMEM_STRB,
    output logic [DW-1:0] DMEM_RDATA,
    output logic          DMEM_BUSY,
    output logic          DMEM_DONE,
    output logic          DMEM_ERR,
    output logic          BUS_VALID,
    output logic          BUS_WRITE,
    output logic [AW-1:0] BUS_ADDR,
    output logic [DW-1:0] BUS_WDATA,
    output logic [3:0]    BUS_STRB,
    input  logic          BUS_READY,
    input  logic [DW-1:0] BUS_RDATA
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t state, state_nx;

    logic          pend_i, pend_d;
    logic [AW-1:0] addr_i, addr_d;
    logic [DW-1:0] wdata_d;
    logic [3:0]    strb_d;
    logic          write_d;
    logic          last_d;      // 1 when the most recent grant went to the data side
    logic          done_i, done_d;
    logic          err_i, err_d;
    logic [DW-1:0] rdata_i, rdata_d;

    logic          take_i, take_d;
    logic          want_i, want_d;
    logic          granted;
    logic          handshake;
    logic          timeout_hit;
    logic          xfer_end;

    // A strobe is only accepted while that side is not already busy.
    assign take_i = IMEM_REQ & ~pend_i;
    assign take_d = (DMEM_REQ_LOAD | DMEM_REQ_STORE) & ~pend_d;

    // The strobe itself counts as pending so IDLE can grant on that same edge.
    assign want_i = pend_i | IMEM_REQ;
    assign want_d = pend_d | DMEM_REQ_LOAD | DMEM_REQ_STORE;

    assign granted   = (state == GRANT_I) || (state == GRANT_D);
    assign BUS_VALID = granted & ~timeout_hit;
    assign handshake = BUS_VALID & BUS_READY;
    assign xfer_end  = granted & (handshake | timeout_hit);

`ifdef CORE_MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tcnt;

    assign timeout_hit = granted && (tcnt == CW'(TIMEOUT_CYCLES));

    // Every grant is preceded by an IDLE cycle, so clearing in IDLE restarts
    // the count for each new grant.
    always_ff @(posedge CLK) begin
        if (!NRST || state == IDLE) begin
            tcnt <= '0;
        end else if (!BUS_READY && !timeout_hit) begin
            tcnt <= tcnt + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (want_i && want_d) begin
                    state_nx = last_d ? GRANT_I : GRANT_D;
                end else if (want_d) begin
                    state_nx = GRANT_D;
                end else if (want_i) begin
                    state_nx = GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (xfer_end) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Pending registers. Capture and clear never coincide on one side:
    // capture needs the side idle, clearing needs it granted.
    always_ff @(posedge CLK) begin
        if (!NRST) begin
            pend_i  <= 1'b0;
            pend_d  <= 1'b0;
            addr_i  <= '0;
            addr_d  <= '0;
            wdata_d <= '0;
            strb_d  <= '0;
            write_d <= 1'b0;
            last_d  <= 1'b0;
        end else begin
            if (take_i) begin
                pend_i <= 1'b1;
                addr_i <= IMEM_ADDR;
            end else if (state == GRANT_I && xfer_end) begin
                pend_i <= 1'b0;
            end

            if (take_d) begin
                pend_d  <= 1'b1;
                addr_d  <= DMEM_ADDR;
                wdata_d <= DMEM_WDATA;
                strb_d  <= DMEM_STRB;
                write_d <= DMEM_REQ_STORE;
            end else if (state == GRANT_D && xfer_end) begin
                pend_d <= 1'b0;
            end

            if (state == IDLE && state_nx == GRANT_D) begin
                last_d <= 1'b1;
            end else if (state == IDLE && state_nx == GRANT_I) begin
                last_d <= 1'b0;
            end
        end
    end

    // Completion: one-cycle DONE pulses and held read data.
    always_ff @(posedge CLK) begin
        if (!NRST) begin
            done_i  <= 1'b0;
            done_d  <= 1'b0;
            err_i   <= 1'b0;
            err_d   <= 1'b0;
            rdata_i <= '0;
            rdata_d <= '0;
        end else begin
            done_i <= (state == GRANT_I) && xfer_end;
            done_d <= (state == GRANT_D) && xfer_end;
            err_i  <= (state == GRANT_I) && timeout_hit;
            err_d  <= (state == GRANT_D) && timeout_hit;
            if (state == GRANT_I && timeout_hit) begin
                rdata_i <= '0;
            end else if (state == GRANT_I && handshake) begin
                rdata_i <= BUS_RDATA;
            end
            if (state == GRANT_D && timeout_hit) begin
                rdata_d <= '0;
            end else if (state == GRANT_D && handshake && !write_d) begin
                rdata_d <= BUS_RDATA;
            end
        end
    end

    // Bus fields come straight from the granted pending register, so they
    // stay stable for as long as the grant lasts.
    always_comb begin
        BUS_WRITE = 1'b0;
        BUS_ADDR  = '0;
        BUS_WDATA = '0;
        BUS_STRB  = 4'h0;
        case (state)
            GRANT_I: begin
                BUS_ADDR = addr_i;
                BUS_STRB = 4'hF;
            end
            GRANT_D: begin
                BUS_WRITE = write_d;
                BUS_ADDR  = addr_d;
                BUS_WDATA = write_d ? wdata_d : '0;
                BUS_STRB  = write_d ? strb_d : 4'hF;
            end
            default: ;
        endcase
    end

    assign IMEM_BUSY  = pend_i;
    assign DMEM_BUSY  = pend_d;
    assign IMEM_DONE  = done_i;
    assign DMEM_DONE  = done_d;
    assign IMEM_RDATA = rdata_i;
    assign DMEM_RDATA = rdata_d;
`ifdef CORE_MEM_ARB_TIMEOUT_EN
    assign IMEM_ERR   = err_i;
    assign DMEM_ERR   = err_d;
`else
    assign IMEM_ERR   = 1'b0;
    assign DMEM_ERR   = 1'b0;
    logic unused_err;
    assign unused_err = err_i | err_d;
`endif

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - self-checking bench for core_mem_arbiter

module tb_core_mem_arbiter;

    logic        CLK = 1'b0;
    logic        NRST;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_RDATA;
    logic        IMEM_BUSY, IMEM_DONE, IMEM_ERR;
    logic        DMEM_REQ_LOAD, DMEM_REQ_STORE;
    logic [31:0] DMEM_ADDR, DMEM_WDATA;
    logic [3:0]  DMEM_STRB;
    logic [31:0] DMEM_RDATA;
    logic        DMEM_BUSY, DMEM_DONE, DMEM_ERR;
    logic        BUS_VALID, BUS_WRITE;
    logic [31:0] BUS_ADDR, BUS_WDATA;
    logic [3:0]  BUS_STRB;
    logic        BUS_READY;
    logic [31:0] BUS_RDATA;

    always #5 CLK = ~CLK;

    core_mem_arbiter dut (
        .CLK(CLK), .NRST(NRST),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_RDATA(IMEM_RDATA),
        .IMEM_BUSY(IMEM_BUSY), .IMEM_DONE(IMEM_DONE), .IMEM_ERR(IMEM_ERR),
        .DMEM_REQ_LOAD(DMEM_REQ_LOAD), .DMEM_REQ_STORE(DMEM_REQ_STORE),
        .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA), .DMEM_STRB(DMEM_STRB),
        .DMEM_RDATA(DMEM_RDATA), .DMEM_BUSY(DMEM_BUSY), .DMEM_DONE(DMEM_DONE),
        .DMEM_ERR(DMEM_ERR),
        .BUS_VALID(BUS_VALID), .BUS_WRITE(BUS_WRITE), .BUS_ADDR(BUS_ADDR),
        .BUS_WDATA(BUS_WDATA), .BUS_STRB(BUS_STRB), .BUS_READY(BUS_READY),
        .BUS_RDATA(BUS_RDATA)
    );

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0000_0013 : {a[15:0], ~a[15:0]};
    endfunction

    assign BUS_RDATA = mem_of(BUS_ADDR);

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } beat_t;

    beat_t       bus_q[$];
    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];
    logic [31:0] model_d;
    int          checks = 0;
    int          errors = 0;
    int          i_dones = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs at each negedge: scores bus beats and completions against the queues.
    task automatic mon();
        beat_t b;
        if (BUS_VALID && BUS_READY) begin
            chk("bus_q_nonempty", 64'(bus_q.size() != 0), 64'd1);
            if (bus_q.size() != 0) begin
                b = bus_q.pop_front();
                chk("bus_addr", 64'(BUS_ADDR), 64'(b.addr));
                chk("bus_write", 64'(BUS_WRITE), 64'(b.write));
                chk("bus_strb", 64'(BUS_STRB), 64'(b.strb));
                if (b.write) chk("bus_wdata", 64'(BUS_WDATA), 64'(b.wdata));
            end
        end
        if (IMEM_DONE) begin
            i_dones++;
            chk("imem_q_nonempty", 64'(exp_i.size() != 0), 64'd1);
            if (exp_i.size() != 0) chk("imem_rdata", 64'(IMEM_RDATA), 64'(exp_i.pop_front()));
            chk("imem_err", 64'(IMEM_ERR), 64'd0);
            chk("imem_busy_in_done", 64'(IMEM_BUSY), 64'd0);
        end
        if (DMEM_DONE) begin
            chk("dmem_q_nonempty", 64'(exp_d.size() != 0), 64'd1);
            if (exp_d.size() != 0) chk("dmem_rdata", 64'(DMEM_RDATA), 64'(exp_d.pop_front()));
            chk("dmem_err", 64'(DMEM_ERR), 64'd0);
        end
        if (IMEM_DONE || DMEM_DONE) chk("valid_in_done", 64'(BUS_VALID), 64'd0);
    endtask

    task automatic at_neg();
        @(negedge CLK);
        mon();
    endtask

    task automatic to_pos();
        @(posedge CLK);
        #1;
        IMEM_REQ       = 1'b0;
        DMEM_REQ_LOAD  = 1'b0;
        DMEM_REQ_STORE = 1'b0;
    endtask

    task automatic push_i(input logic [31:0] a);
        beat_t b;
        b.addr = a; b.write = 1'b0; b.wdata = '0; b.strb = 4'hF;
        bus_q.push_back(b);
        exp_i.push_back(mem_of(a));
    endtask

    task automatic push_d_load(input logic [31:0] a);
        beat_t b;
        b.addr = a; b.write = 1'b0; b.wdata = '0; b.strb = 4'hF;
        bus_q.push_back(b);
        model_d = mem_of(a);
        exp_d.push_back(model_d);
    endtask

    task automatic push_d_store(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
        beat_t b;
        b.addr = a; b.write = 1'b1; b.wdata = w; b.strb = s;
        bus_q.push_back(b);
        exp_d.push_back(model_d);
    endtask

    initial begin
        NRST = 1'b0; IMEM_REQ = 1'b0; IMEM_ADDR = '0;
        DMEM_REQ_LOAD = 1'b0; DMEM_REQ_STORE = 1'b0;
        DMEM_ADDR = '0; DMEM_WDATA = '0; DMEM_STRB = '0; BUS_READY = 1'b0;
        model_d = '0;
        repeat (2) @(posedge CLK);
        #1;
        // Reset state
        chk("rst_valid", 64'(BUS_VALID), 64'd0);
        chk("rst_write", 64'(BUS_WRITE), 64'd0);
        chk("rst_addr", 64'(BUS_ADDR), 64'd0);
        chk("rst_strb", 64'(BUS_STRB), 64'd0);
        chk("rst_busy", 64'({IMEM_BUSY, DMEM_BUSY}), 64'd0);
        chk("rst_done", 64'({IMEM_DONE, DMEM_DONE, IMEM_ERR, DMEM_ERR}), 64'd0);
        chk("rst_rdata", 64'({IMEM_RDATA, DMEM_RDATA}), 64'd0);
        NRST = 1'b1;
        to_pos();

        // Minimum-latency fetch
        BUS_READY = 1'b1;
        IMEM_REQ = 1'b1; IMEM_ADDR = 32'h100; push_i(32'h100);
        at_neg(); chk("t1_c0_busy", 64'(IMEM_BUSY), 64'd0);
        to_pos();
        at_neg();
        chk("t1_c1_valid", 64'(BUS_VALID), 64'd1);
        chk("t1_c1_addr", 64'(BUS_ADDR), 64'h100);
        chk("t1_c1_busy", 64'(IMEM_BUSY), 64'd1);
        to_pos();
        at_neg();
        chk("t1_c2_done", 64'(IMEM_DONE), 64'd1);
        chk("t1_c2_rdata", 64'(IMEM_RDATA), 64'h13);
        to_pos();
        at_neg(); chk("t1_c3_done_once", 64'(IMEM_DONE), 64'd0);
        to_pos();

        // First tie after reset: DMEM first
        NRST = 1'b0; to_pos(); NRST = 1'b1; model_d = '0;
        IMEM_REQ = 1'b1; IMEM_ADDR = 32'h200;
        DMEM_REQ_LOAD = 1'b1; DMEM_ADDR = 32'h300;
        push_d_load(32'h300); push_i(32'h200);
        at_neg(); to_pos();
        at_neg(); chk("t2_c1_d_first", 64'({BUS_VALID, BUS_ADDR}), {31'd0, 1'b1, 32'h300});
        to_pos();
        at_neg(); chk("t2_c2_ddone", 64'(DMEM_DONE), 64'd1);
        to_pos();
        at_neg(); chk("t2_c3_i_grant", 64'({BUS_VALID, BUS_ADDR}), {31'd0, 1'b1, 32'h200});
        to_pos();
        at_neg(); chk("t2_c4_idone", 64'(IMEM_DONE), 64'd1);
        to_pos();

        // Store held off by READY for 5 cycles
        BUS_READY = 1'b0;
        DMEM_REQ_STORE = 1'b1; DMEM_ADDR = 32'h2004;
        DMEM_WDATA = 32'hDEADBEEF; DMEM_STRB = 4'b0011;
        push_d_store(32'h2004, 32'hDEADBEEF, 4'b0011);
        at_neg(); to_pos();
        DMEM_ADDR = 32'h0; DMEM_WDATA = 32'h0; DMEM_STRB = 4'h0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 6) BUS_READY = 1'b1;
            at_neg();
            chk("t3_stable", {BUS_VALID, BUS_WRITE, BUS_STRB, BUS_ADDR[25:0], BUS_WDATA},
                {1'b1, 1'b1, 4'b0011, 26'h2004, 32'hDEADBEEF});
            chk("t3_busy", 64'(DMEM_BUSY), 64'd1);
            chk("t3_nodone", 64'(DMEM_DONE), 64'd0);
            to_pos();
        end
        at_neg();
        chk("t3_done", 64'(DMEM_DONE), 64'd1);
        chk("t3_rdata_kept", 64'(DMEM_RDATA), 64'(mem_of(32'h300)));
        to_pos();

        // Three ties after reset alternate D,I; a fetch strobe while busy is dropped
        NRST = 1'b0; to_pos(); NRST = 1'b1; model_d = '0;
        i_dones = 0;
        for (int t = 0; t < 3; t++) begin
            IMEM_REQ = 1'b1; IMEM_ADDR = 32'h1000 + 32'(t * 4);
            DMEM_REQ_LOAD = 1'b1; DMEM_ADDR = 32'h5000 + 32'(t * 8);
            push_d_load(32'h5000 + 32'(t * 8)); push_i(32'h1000 + 32'(t * 4));
            at_neg(); to_pos();
            if (t == 0) begin
                IMEM_REQ = 1'b1; IMEM_ADDR = 32'h999;
            end
            for (int c = 1; c <= 5; c++) begin
                at_neg(); to_pos();
            end
        end
        chk("t4_imem_dones", 64'(i_dones), 64'd3);
        chk("t4_bus_q_empty", 64'(bus_q.size()), 64'd0);

        // Reset in the middle of a stalled data grant
        BUS_READY = 1'b0;
        DMEM_REQ_LOAD = 1'b1; DMEM_ADDR = 32'h400;
        at_neg(); to_pos();
        at_neg(); chk("t5_granted", 64'({BUS_VALID, BUS_ADDR}), {31'd0, 1'b1, 32'h400});
        NRST = 1'b0;
        to_pos();
        at_neg();
        chk("t5_valid", 64'(BUS_VALID), 64'd0);
        chk("t5_busy", 64'({IMEM_BUSY, DMEM_BUSY}), 64'd0);
        chk("t5_done", 64'({IMEM_DONE, DMEM_DONE}), 64'd0);
        chk("t5_rdata", 64'(DMEM_RDATA), 64'd0);
        NRST = 1'b1; model_d = '0;
        to_pos();
        BUS_READY = 1'b1;
        IMEM_REQ = 1'b1; IMEM_ADDR = 32'h100; push_i(32'h100);
        for (int c = 0; c < 4; c++) begin
            at_neg(); to_pos();
        end

        chk("end_bus_q", 64'(bus_q.size()), 64'd0);
        chk("end_exp_i", 64'(exp_i.size()), 64'd0);
        chk("end_exp_d", 64'(exp_d.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
